// File: rtl/dec_num_parser.sv
// dec_num_parser: folds ASCII decimal digits from the RX FIFO into unsigned binary numbers
//
// Ports:
//   iCLK         system clock, all logic on the rising edge
//   iRST         synchronous reset, active-high
//   iFIFO_EMPTY  RX FIFO empty flag
//   iFIFO_DATA   RX FIFO read data, valid the cycle after oFIFO_RD
//   oFIFO_RD     FIFO read strobe, one-cycle pulse per byte
//   oNUM         assembled number, stable while oNUM_VALID is high
//   oNUM_VALID   result available
//   iNUM_READY   consumer accepts the result when oNUM_VALID & iNUM_READY
//   oNUM_ERR     qualifies oNUM: overflow or illegal character in this token
module dec_num_parser #(
    parameter int WIDTH = 16
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iFIFO_EMPTY,
    input  logic [7:0]       iFIFO_DATA,
    output logic             oFIFO_RD,
    output logic [WIDTH-1:0] oNUM,
    output logic             oNUM_VALID,
    input  logic             iNUM_READY,
    output logic             oNUM_ERR
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT} state_t;

    localparam logic [WIDTH+3:0] MAX_VAL = {4'b0, {WIDTH{1'b1}}};

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0] r_num, w_num_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_bad, w_bad_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_err, w_err_nxt;
    logic             w_is_digit, w_is_delim, w_sat;
    logic [WIDTH+3:0] w_prod;

    assign w_is_digit = (iFIFO_DATA >= 8'h30) && (iFIFO_DATA <= 8'h39);
    assign w_is_delim = (iFIFO_DATA == 8'h20) || (iFIFO_DATA == 8'h2C) ||
                        (iFIFO_DATA == 8'h0D) || (iFIFO_DATA == 8'h0A);
    // acc*10 + d as (acc<<3)+(acc<<1)+d, four guard bits are enough for any WIDTH
    assign w_prod = ({4'b0, r_acc} << 3) + ({4'b0, r_acc} << 1) + {{WIDTH{1'b0}}, iFIFO_DATA[3:0]};
    // once saturated the token stays pinned at all ones
    assign w_sat  = r_ovf || (w_prod > MAX_VAL);

    // read only from idle, never into an empty FIFO and never in a reset cycle
    assign oFIFO_RD   = (r_state == S_IDLE) && !iFIFO_EMPTY && !iRST;
    assign oNUM       = r_num;
    assign oNUM_VALID = r_valid;
    assign oNUM_ERR   = r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_num_nxt   = r_num;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_bad_nxt   = r_bad;
        w_valid_nxt = r_valid;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: w_state_nxt = iFIFO_EMPTY ? S_IDLE : S_WAIT;
            S_WAIT: begin
                w_state_nxt = S_IDLE;
                if (w_is_digit) begin
                    w_acc_nxt = w_sat ? {WIDTH{1'b1}} : w_prod[WIDTH-1:0];
                    w_ovf_nxt = w_sat;
                    w_cnt_nxt = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
                end else if (w_is_delim) begin
                    // a delimiter with nothing collected is dropped silently
                    if (r_cnt != 8'd0 || r_bad) begin
                        w_num_nxt   = r_acc;
                        w_err_nxt   = r_ovf | r_bad;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_OUT;
                    end
                end else begin
                    w_bad_nxt = 1'b1;
                end
            end
            S_OUT: begin
                if (iNUM_READY) begin
                    w_valid_nxt = 1'b0;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                    w_bad_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_num   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_bad   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_num   <= w_num_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
            r_bad   <= w_bad_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end
endmodule
